// File: rtl/fm_demodulator_pkg.sv
// Shared defaults and helpers for the zero-crossing FM demodulator.
// The saturate helper works on int so callers of any width can share it.
package fm_demodulator_pkg;

  localparam int unsigned DefD   = 5;
  localparam int unsigned DefA   = 8;
  localparam int unsigned DefW   = 10;
  localparam int unsigned DefC   = 10;
  localparam int unsigned DefHys = 1;

  function automatic int unsigned midscale(input int unsigned d);
    return 32'd1 << (d - 32'd1);
  endfunction

  localparam int unsigned DefMidscale = midscale(DefD);

  // Clamp val to the range of a width-bit two's complement number.
  function automatic int sat_signed(input int val, input int unsigned width);
    int hi;
    int lo;
    hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 32'd1));
    if (val > hi) begin
      return hi;
    end
    if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/fm_demodulator_zc_detector.sv
// Input register plus hysteresis comparator; crossing is high in the clock
// where the comparator is about to go lo->hi.
module fm_zc_detector
  import fm_demodulator_pkg::*;
#(
  parameter int unsigned D   = DefD,
  parameter int unsigned HYS = DefHys
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] rf,
  output logic         crossing
);

  localparam logic [D-1:0] Mid  = D'(midscale(D));
  localparam logic [D:0]   HiTh = (D+1)'(midscale(D) + HYS);
  localparam logic [D:0]   LoTh = (D+1)'(midscale(D) - HYS);

  logic [D-1:0] rf_q;
  logic         cmp_q;
  logic         cmp_d;
  logic         above;
  logic         below;

  always_comb begin
    above = {1'b0, rf_q} >= HiTh;
    below = {1'b0, rf_q} <= LoTh;
    cmp_d = cmp_q;
    if (!cmp_q && above) begin
      cmp_d = 1'b1;
    end else if (cmp_q && below) begin
      cmp_d = 1'b0;
    end
  end

  assign crossing = !cmp_q && above;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q  <= Mid;
      cmp_q <= 1'b0;
    end else begin
      rf_q  <= rf;
      cmp_q <= cmp_d;
    end
  end

endmodule

// File: rtl/fm_demodulator.sv
// Counts rising carrier crossings per 2**W-clock window and converts the
// count's deviation from the nominal carrier into a saturated audio sample.
module fm_demodulator
  import fm_demodulator_pkg::*;
#(
  parameter int unsigned D   = DefD,
  parameter int unsigned A   = DefA,
  parameter int unsigned W   = DefW,
  parameter int unsigned C   = DefC,
  parameter int unsigned HYS = DefHys
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] rf,
  input  logic [C-1:0] center,
  input  logic [1:0]   gain,
  output logic [A-1:0] audio,
  output logic         audio_valid,
  output logic         carrier_det
);

  logic crossing;

  fm_zc_detector #(
    .D   (D),
    .HYS (HYS)
  ) u_zc (
    .clk      (clk),
    .rst_n    (rst_n),
    .rf       (rf),
    .crossing (crossing)
  );

  logic [W-1:0] win_q;
  logic [C-1:0] count_q;
  logic [C-1:0] total_q;
  logic [C-1:0] center_q;
  logic [1:0]   gain_q;
  logic         pend_q;
  logic [A-1:0] audio_q;
  logic         valid_q;
  logic         det_q;

  logic                term;
  logic [C:0]          count_sum;
  logic [C-1:0]        count_sat;
  logic signed [C:0]   diff;
  logic signed [C+4:0] diff_ext;
  logic signed [C+4:0] scaled;
  int                  sat_val;
  logic                det_d;
  logic [A-1:0]        audio_d;

  always_comb begin
    term      = &win_q;
    count_sum = {1'b0, count_q} + (C+1)'(crossing);
    count_sat = count_sum[C] ? '1 : count_sum[C-1:0];
    // Result path works on the totals staged at the terminal edge.
    diff      = $signed({1'b0, total_q}) - $signed({1'b0, center_q});
    diff_ext  = {{4{diff[C]}}, diff};
    scaled    = diff_ext <<< gain_q;
    sat_val   = sat_signed(int'(scaled), A);
    det_d     = total_q >= (center_q >> 1);
    audio_d   = det_d ? A'(sat_val) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q    <= '0;
      count_q  <= '0;
      total_q  <= '0;
      center_q <= '0;
      gain_q   <= '0;
      pend_q   <= 1'b0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
      det_q    <= 1'b0;
    end else begin
      win_q   <= win_q + W'(1);
      count_q <= term ? '0 : count_sat;
      pend_q  <= term;
      valid_q <= pend_q;
      if (term) begin
        total_q  <= count_sat;
        center_q <= center;
        gain_q   <= gain;
      end
      if (pend_q) begin
        audio_q <= audio_d;
        det_q   <= det_d;
      end
    end
  end

  assign audio       = audio_q;
  assign audio_valid = valid_q;
  assign carrier_det = det_q;

endmodule

// File: tb/tb_fm_demodulator.sv
// Table-driven check of the FM demodulator: each vector sets an RF pattern,
// skips the mixed window, then scores the next full-window strobe.
module tb_fm_demodulator;

  localparam int D = 5;
  localparam int A = 8;
  localparam int W = 10;
  localparam int C = 10;
  localparam int Win = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [D-1:0] rf = 5'd16;
  logic [C-1:0] center = 10'd128;
  logic [1:0]   gain = 2'd0;
  logic [A-1:0] audio;
  logic         audio_valid;
  logic         carrier_det;

  fm_demodulator #(
    .D   (D),
    .A   (A),
    .W   (W),
    .C   (C),
    .HYS (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rf          (rf),
    .center      (center),
    .gain        (gain),
    .audio       (audio),
    .audio_valid (audio_valid),
    .carrier_det (carrier_det)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // RF pattern generator: 0 idle midscale, 1 square 24/8, 2 two-level toggle.
  int gen_mode = 0;
  int gen_period = 8;
  int tog_a = 16;
  int tog_b = 16;
  int gen_epoch = 0;

  initial begin : gen
    int phase;
    int seen;
    phase = 0;
    seen = 0;
    forever begin
      @(posedge clk);
      #2;
      if (seen != gen_epoch) begin
        phase = 0;
        seen = gen_epoch;
      end
      case (gen_mode)
        1: rf = ((phase % gen_period) < gen_period / 2) ? 5'd24 : 5'd8;
        2: rf = (phase % 2 == 0) ? D'(tog_a) : D'(tog_b);
        default: rf = 5'd16;
      endcase
      phase++;
    end
  end

  typedef struct {
    int mode;
    int period;
    int ta;
    int tb;
    int ctr;
    int gn;
    int exp_audio;
    int exp_det;
  } vec_t;

  typedef struct {
    int    audio;
    int    det;
    string name;
  } exp_t;

  exp_t sb[$];

  // Wait for the next strobe, counting clocks and checking audio holds.
  task automatic wait_strobe(output int n, output int hold_ok);
    logic [A-1:0] held;
    held = audio;
    hold_ok = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!audio_valid && audio !== held) hold_ok = 0;
    end while (!audio_valid && n < 3000);
    if (!audio_valid) chk("strobe_timeout", 0, 1);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_audio"}, int'($signed(audio)), e.audio);
      chk({e.name, "_det"}, int'(carrier_det), e.det);
    end
  endtask

  initial begin : main
    vec_t vecs[11];
    int   n;
    int   hold_ok;

    vecs[0]  = '{1, 8, 0, 0, 128, 0, 0, 1};
    vecs[1]  = '{1, 16, 0, 0, 128, 1, -128, 1};
    vecs[2]  = '{1, 16, 0, 0, 128, 0, -64, 1};
    vecs[3]  = '{1, 16, 0, 0, 129, 0, -65, 1};
    vecs[4]  = '{1, 16, 0, 0, 130, 0, 0, 0};
    vecs[5]  = '{2, 2, 16, 17, 128, 0, 0, 0};
    vecs[6]  = '{2, 2, 15, 17, 500, 0, 12, 1};
    vecs[7]  = '{2, 2, 15, 17, 1023, 3, -128, 1};
    vecs[8]  = '{1, 64, 0, 0, 0, 2, 64, 1};
    vecs[9]  = '{1, 8, 0, 0, 120, 2, 32, 1};
    vecs[10] = '{1, 4, 0, 0, 128, 0, 127, 1};

    repeat (2) @(negedge clk);
    chk("rst_audio", int'(audio), 0);
    chk("rst_valid", int'(audio_valid), 0);
    chk("rst_det", int'(carrier_det), 0);
    rst_n = 1'b1;

    // Idle midscale input: no crossings, no carrier.
    sb.push_back('{0, 0, "idle"});
    wait_strobe(n, hold_ok);
    chk("first_strobe_latency", n, Win + 1);
    score();

    for (int i = 0; i < 11; i++) begin
      gen_mode = vecs[i].mode;
      gen_period = vecs[i].period;
      tog_a = vecs[i].ta;
      tog_b = vecs[i].tb;
      center = C'(vecs[i].ctr);
      gain = 2'(vecs[i].gn);
      gen_epoch++;
      sb.push_back('{vecs[i].exp_audio, vecs[i].exp_det, $sformatf("vec%0d", i)});
      wait_strobe(n, hold_ok);
      chk($sformatf("vec%0d_interval_a", i), n, Win);
      chk($sformatf("vec%0d_hold_a", i), hold_ok, 1);
      wait_strobe(n, hold_ok);
      chk($sformatf("vec%0d_interval_b", i), n, Win);
      chk($sformatf("vec%0d_hold_b", i), hold_ok, 1);
      score();
    end

    // Mid-window center change takes effect at this window's strobe.
    gen_mode = 1;
    gen_period = 8;
    center = 10'd128;
    gain = 2'd0;
    gen_epoch++;
    wait_strobe(n, hold_ok);
    sb.push_back('{0, 1, "ctr_before"});
    wait_strobe(n, hold_ok);
    score();
    repeat (299) @(negedge clk);
    center = 10'd100;
    sb.push_back('{28, 1, "ctr_change"});
    wait_strobe(n, hold_ok);
    chk("ctr_change_hold", hold_ok, 1);
    score();

    // One-clock reset at window count 500 discards the partial count.
    center = 10'd128;
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    gen_mode = 0;
    @(negedge clk);
    chk("midrst_audio", int'(audio), 0);
    chk("midrst_valid", int'(audio_valid), 0);
    chk("midrst_det", int'(carrier_det), 0);
    rst_n = 1'b1;
    gen_mode = 1;
    gen_epoch++;
    sb.push_back('{0, 1, "post_rst"});
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      n = k;
      if (audio_valid) break;
    end
    chk("post_rst_latency", n, Win + 1);
    score();
    sb.push_back('{0, 1, "post_rst_next"});
    wait_strobe(n, hold_ok);
    chk("post_rst_interval", n, Win);
    score();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
